// File: rtl/kb_keystate_ctrl.sv
// PS/2 set-2 key-state sequencer: decodes E0/F0 prefixes, tracks shift/capslock,
// and presents each plain key press once through a valid/ready holding register.
module kb_keystate_ctrl #(
    parameter int SUPPRESS_REPEAT = 0,
    parameter int TIMEOUT         = 1000000
) (
    input  logic       clk,
    input  logic       i_sclr_n,
    input  logic [7:0] i_scancode,
    input  logic       i_strobe,
    output logic [7:0] o_scancode,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_ev_shift,
    output logic       o_ev_caps,
    output logic       o_shift,
    output logic       o_capslock,
    output logic       o_ovf
);

    // state     | meaning
    // S_IDLE    | no prefix pending; plain bytes are presses
    // S_EXT     | E0 seen; next byte is an extended key (dropped)
    // S_BRK     | F0 seen; next byte is a released key
    // S_EXT_BRK | E0 F0 seen; next byte is an extended release (dropped)
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_EXT     = 2'd1;
    localparam logic [1:0] S_BRK     = 2'd2;
    localparam logic [1:0] S_EXT_BRK = 2'd3;

    localparam logic [23:0] TMO = 24'(TIMEOUT);

    logic [1:0]  state;
    logic [1:0]  state_nx;
    logic        lshift;
    logic        rshift;
    logic        caps;
    logic        caps_held;
    logic        rep_held;
    logic [7:0]  rep_code;
    logic [23:0] tmr;

    logic is_pfx;
    logic is_mod;
    logic is_reply;
    logic rep_hit;
    logic press;
    logic ev_new;
    logic load;
    logic tmo_hit;

    assign is_pfx   = (i_scancode == 8'hE0) || (i_scancode == 8'hF0);
    assign is_mod   = (i_scancode == 8'h12) || (i_scancode == 8'h59) || (i_scancode == 8'h58);
    assign is_reply = i_scancode inside {8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'hFE, 8'h00, 8'hFF};
    assign rep_hit  = rep_held && (i_scancode == rep_code);
    assign press    = i_strobe && (state == S_IDLE) && !is_pfx && !is_mod && !is_reply;
    assign ev_new   = press && !((SUPPRESS_REPEAT != 0) && rep_hit);
    assign load     = ev_new && (!o_valid || i_ready);
    // Down-counter loaded on every byte; terminal count 1 abandons a stale prefix.
    assign tmo_hit  = (TMO != 24'd0) && (state != S_IDLE) && !i_strobe && (tmr == 24'd1);

    always_comb begin
        state_nx = state;
        if (i_strobe) begin
            case (state)
                S_IDLE: begin
                    if (i_scancode == 8'hE0)      state_nx = S_EXT;
                    else if (i_scancode == 8'hF0) state_nx = S_BRK;
                end
                S_EXT:   state_nx = (i_scancode == 8'hF0) ? S_EXT_BRK : S_IDLE;
                S_BRK:   if (!is_pfx) state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end else if (tmo_hit) begin
            state_nx = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!i_sclr_n) begin
            state      <= S_IDLE;
            tmr        <= 24'd0;
            lshift     <= 1'b0;
            rshift     <= 1'b0;
            caps       <= 1'b0;
            caps_held  <= 1'b0;
            rep_held   <= 1'b0;
            rep_code   <= 8'h00;
            o_scancode <= 8'h00;
            o_valid    <= 1'b0;
            o_ev_shift <= 1'b0;
            o_ev_caps  <= 1'b0;
            o_ovf      <= 1'b0;
        end else begin
            state <= state_nx;

            if (i_strobe)
                tmr <= TMO;
            else if ((state != S_IDLE) && (tmr != 24'd0))
                tmr <= tmr - 24'd1;

            if (i_strobe && (state == S_IDLE)) begin
                if (i_scancode == 8'h12) lshift <= 1'b1;
                if (i_scancode == 8'h59) rshift <= 1'b1;
                // caps_held masks typematic repeats of the capslock key itself
                if ((i_scancode == 8'h58) && !caps_held) begin
                    caps      <= ~caps;
                    caps_held <= 1'b1;
                end
            end

            if (i_strobe && (state == S_BRK) && !is_pfx) begin
                if (i_scancode == 8'h12) lshift    <= 1'b0;
                if (i_scancode == 8'h59) rshift    <= 1'b0;
                if (i_scancode == 8'h58) caps_held <= 1'b0;
                if (rep_hit)             rep_held  <= 1'b0;
            end

            if (ev_new) begin
                rep_code <= i_scancode;
                rep_held <= 1'b1;
            end

            if (load) begin
                o_scancode <= i_scancode;
                o_ev_shift <= lshift | rshift;
                o_ev_caps  <= caps;
                o_valid    <= 1'b1;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end

            if (ev_new && o_valid && !i_ready)
                o_ovf <= 1'b1;
        end
    end

    assign o_shift    = lshift | rshift;
    assign o_capslock = caps;

endmodule

// File: tb/tb_kb_keystate_ctrl.sv
// Bench for kb_keystate_ctrl: vector table, hand sequences and random bytes
// checked against a prefix/modifier/holding-register reference model.
module tb_kb_keystate_ctrl;

    localparam int TMO = 8;

    logic       clk = 1'b0;
    logic       sclr_n;
    logic       strobe;
    logic       ready;
    logic [7:0] scan;
    logic [7:0] code_o [2];
    logic       valid_o [2];
    logic       evs_o [2];
    logic       evc_o [2];
    logic       shift_o [2];
    logic       caps_o [2];
    logic       ovf_o [2];

    always #5 clk = ~clk;

    kb_keystate_ctrl #(.SUPPRESS_REPEAT(0), .TIMEOUT(TMO)) dut0 (
        .clk(clk), .i_sclr_n(sclr_n), .i_scancode(scan), .i_strobe(strobe),
        .o_scancode(code_o[0]), .o_valid(valid_o[0]), .i_ready(ready),
        .o_ev_shift(evs_o[0]), .o_ev_caps(evc_o[0]), .o_shift(shift_o[0]),
        .o_capslock(caps_o[0]), .o_ovf(ovf_o[0]));

    kb_keystate_ctrl #(.SUPPRESS_REPEAT(1), .TIMEOUT(TMO)) dut1 (
        .clk(clk), .i_sclr_n(sclr_n), .i_scancode(scan), .i_strobe(strobe),
        .o_scancode(code_o[1]), .o_valid(valid_o[1]), .i_ready(ready),
        .o_ev_shift(evs_o[1]), .o_ev_caps(evc_o[1]), .o_shift(shift_o[1]),
        .o_capslock(caps_o[1]), .o_ovf(ovf_o[1]));

    typedef struct {
        bit         ext;
        bit         brk;
        int         gap;
        bit         lsh;
        bit         rsh;
        bit         caps;
        bit         caps_held;
        bit         rep_held;
        logic [7:0] rep;
        bit         valid;
        logic [7:0] code;
        bit         evs;
        bit         evc;
        bit         ovf;
    } mdl_t;

    typedef struct {
        bit         stb;
        logic [7:0] b;
        bit         rdy;
        bit         v;
        logic [7:0] code;
        bit         evs;
        bit         evc;
        bit         sh;
        bit         cp;
        bit         ovf;
    } vec_t;

    mdl_t m [2];
    vec_t vecs [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void chk(string nm, logic [7:0] act, logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void mreset(int k);
        m[k].ext = 0; m[k].brk = 0; m[k].gap = 0;
        m[k].lsh = 0; m[k].rsh = 0; m[k].caps = 0; m[k].caps_held = 0;
        m[k].rep_held = 0; m[k].rep = 8'h00;
        m[k].valid = 0; m[k].code = 8'h00; m[k].evs = 0; m[k].evc = 0; m[k].ovf = 0;
    endfunction

    // One clock edge of the reference behaviour for model k.
    function automatic void mstep(int k, bit sr, bit stb, logic [7:0] b, bit rdy);
        bit ev = 0;
        bit ev_s = m[k].lsh | m[k].rsh;
        bit ev_c = m[k].caps;
        if (!stb) begin
            m[k].gap++;
            if (TMO != 0 && m[k].gap >= TMO) begin
                m[k].ext = 0;
                m[k].brk = 0;
            end
        end else begin
            m[k].gap = 0;
            if (m[k].ext && m[k].brk) begin
                m[k].ext = 0; m[k].brk = 0;
            end else if (m[k].brk) begin
                if (b != 8'hE0 && b != 8'hF0) begin
                    if (b == 8'h12) m[k].lsh = 0;
                    if (b == 8'h59) m[k].rsh = 0;
                    if (b == 8'h58) m[k].caps_held = 0;
                    if (m[k].rep_held && b == m[k].rep) m[k].rep_held = 0;
                    m[k].brk = 0;
                end
            end else if (m[k].ext) begin
                if (b == 8'hF0) m[k].brk = 1;
                else m[k].ext = 0;
            end else begin
                case (b)
                    8'hE0: m[k].ext = 1;
                    8'hF0: m[k].brk = 1;
                    8'h12: m[k].lsh = 1;
                    8'h59: m[k].rsh = 1;
                    8'h58: if (!m[k].caps_held) begin
                        m[k].caps = !m[k].caps;
                        m[k].caps_held = 1;
                    end
                    8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'hFE, 8'h00, 8'hFF: ;
                    default: if (!(sr && m[k].rep_held && b == m[k].rep)) begin
                        m[k].rep = b;
                        m[k].rep_held = 1;
                        ev = 1;
                    end
                endcase
            end
        end
        if (ev) begin
            if (!m[k].valid || rdy) begin
                m[k].valid = 1; m[k].code = b; m[k].evs = ev_s; m[k].evc = ev_c;
            end else begin
                m[k].ovf = 1;
            end
        end else if (m[k].valid && rdy) begin
            m[k].valid = 0;
        end
    endfunction

    function automatic void cmp_model(int k);
        chk($sformatf("d%0d valid", k), 8'(valid_o[k]), 8'(m[k].valid));
        if (m[k].valid) begin
            chk($sformatf("d%0d scancode", k), code_o[k], m[k].code);
            chk($sformatf("d%0d ev_shift", k), 8'(evs_o[k]), 8'(m[k].evs));
            chk($sformatf("d%0d ev_caps", k), 8'(evc_o[k]), 8'(m[k].evc));
        end
        chk($sformatf("d%0d shift", k), 8'(shift_o[k]), 8'(m[k].lsh | m[k].rsh));
        chk($sformatf("d%0d capslock", k), 8'(caps_o[k]), 8'(m[k].caps));
        chk($sformatf("d%0d ovf", k), 8'(ovf_o[k]), 8'(m[k].ovf));
    endfunction

    task automatic cyc(bit stb, logic [7:0] b, bit rdy);
        @(negedge clk);
        strobe = stb;
        scan   = b;
        ready  = rdy;
        @(posedge clk);
        mstep(0, 1'b0, stb, b, rdy);
        mstep(1, 1'b1, stb, b, rdy);
        #1;
        cmp_model(0);
        cmp_model(1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        sclr_n = 1'b0;
        strobe = 1'b0;
        scan   = 8'h00;
        ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mreset(0);
        mreset(1);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst d%0d valid", k), 8'(valid_o[k]), 8'h00);
            chk($sformatf("rst d%0d scancode", k), code_o[k], 8'h00);
            chk($sformatf("rst d%0d shift", k), 8'(shift_o[k]), 8'h00);
            chk($sformatf("rst d%0d capslock", k), 8'(caps_o[k]), 8'h00);
            chk($sformatf("rst d%0d ovf", k), 8'(ovf_o[k]), 8'h00);
        end
        sclr_n = 1'b1;
    endtask

    task automatic add(bit stb, logic [7:0] b, bit rdy, bit v, logic [7:0] code,
                       bit evs, bit evc, bit sh, bit cp, bit ovf);
        vec_t t;
        t.stb = stb; t.b = b; t.rdy = rdy; t.v = v; t.code = code;
        t.evs = evs; t.evc = evc; t.sh = sh; t.cp = cp; t.ovf = ovf;
        vecs.push_back(t);
    endtask

    logic [7:0] pool [16];
    int         ev_cnt [2];

    initial begin
        sclr_n = 1'b0;
        strobe = 1'b0;
        scan   = 8'h00;
        ready  = 1'b1;

        // stb  byte  rdy | valid code evs evc shift caps ovf
        add(1, 8'h1C, 1,   1, 8'h1C, 0, 0, 0, 0, 0);
        add(0, 8'h00, 1,   0, 8'h00, 0, 0, 0, 0, 0);
        add(1, 8'h12, 1,   0, 8'h00, 0, 0, 1, 0, 0);
        add(1, 8'h1C, 1,   1, 8'h1C, 1, 0, 1, 0, 0);
        add(1, 8'hF0, 1,   0, 8'h00, 0, 0, 1, 0, 0);
        add(1, 8'h1C, 1,   0, 8'h00, 0, 0, 1, 0, 0);
        add(1, 8'hF0, 1,   0, 8'h00, 0, 0, 1, 0, 0);
        add(1, 8'h12, 1,   0, 8'h00, 0, 0, 0, 0, 0);
        add(1, 8'h58, 1,   0, 8'h00, 0, 0, 0, 1, 0);
        add(1, 8'h58, 1,   0, 8'h00, 0, 0, 0, 1, 0);
        add(1, 8'hF0, 1,   0, 8'h00, 0, 0, 0, 1, 0);
        add(1, 8'h58, 1,   0, 8'h00, 0, 0, 0, 1, 0);
        add(1, 8'h58, 1,   0, 8'h00, 0, 0, 0, 0, 0);
        add(1, 8'hF0, 1,   0, 8'h00, 0, 0, 0, 0, 0);
        add(1, 8'h58, 1,   0, 8'h00, 0, 0, 0, 0, 0);
        add(1, 8'h1C, 0,   1, 8'h1C, 0, 0, 0, 0, 0);
        add(1, 8'h32, 0,   1, 8'h1C, 0, 0, 0, 0, 1);
        add(0, 8'h00, 0,   1, 8'h1C, 0, 0, 0, 0, 1);
        add(1, 8'h21, 1,   1, 8'h21, 0, 0, 0, 0, 1);
        add(0, 8'h00, 1,   0, 8'h00, 0, 0, 0, 0, 1);
        add(1, 8'h58, 1,   0, 8'h00, 0, 0, 0, 1, 1);
        add(1, 8'h1C, 1,   1, 8'h1C, 0, 1, 0, 1, 1);
        add(0, 8'h00, 1,   0, 8'h00, 0, 0, 0, 1, 1);

        do_reset();

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].stb, vecs[i].b, vecs[i].rdy);
            chk($sformatf("vec%0d valid", i), 8'(valid_o[0]), 8'(vecs[i].v));
            if (vecs[i].v) begin
                chk($sformatf("vec%0d scancode", i), code_o[0], vecs[i].code);
                chk($sformatf("vec%0d ev_shift", i), 8'(evs_o[0]), 8'(vecs[i].evs));
                chk($sformatf("vec%0d ev_caps", i), 8'(evc_o[0]), 8'(vecs[i].evc));
            end
            chk($sformatf("vec%0d shift", i), 8'(shift_o[0]), 8'(vecs[i].sh));
            chk($sformatf("vec%0d capslock", i), 8'(caps_o[0]), 8'(vecs[i].cp));
            chk($sformatf("vec%0d ovf", i), 8'(ovf_o[0]), 8'(vecs[i].ovf));
        end

        // Extended keys, fake shift and extended breaks produce nothing.
        do_reset();
        ev_cnt[0] = 0;
        begin
            logic [7:0] ext_seq [7];
            ext_seq = '{8'hE0, 8'h12, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
            for (int i = 0; i < 7; i++) begin
                cyc(1'b1, ext_seq[i], 1'b1);
                if (valid_o[0]) ev_cnt[0]++;
            end
        end
        chk("ext events", 8'(ev_cnt[0]), 8'd0);
        chk("ext shift", 8'(shift_o[0]), 8'd0);

        // A byte arriving on the last allowed prefix cycle is still consumed by the prefix.
        cyc(1'b1, 8'hE0, 1'b1);
        repeat (TMO - 1) cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b1, 8'h1C, 1'b1);
        chk("tmo edge valid", 8'(valid_o[0]), 8'd0);
        cyc(1'b1, 8'hE0, 1'b1);
        repeat (TMO) cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b1, 8'h1C, 1'b1);
        chk("tmo expired valid", 8'(valid_o[0]), 8'd1);
        chk("tmo expired code", code_o[0], 8'h1C);

        // Typematic repeat: suppressed instance sees two events, plain instance four.
        do_reset();
        ev_cnt[0] = 0;
        ev_cnt[1] = 0;
        begin
            logic [7:0] rep_seq [6];
            rep_seq = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
            for (int i = 0; i < 6; i++) begin
                cyc(1'b1, rep_seq[i], 1'b1);
                if (valid_o[0]) ev_cnt[0]++;
                if (valid_o[1]) ev_cnt[1]++;
            end
        end
        cyc(1'b0, 8'h00, 1'b1);
        chk("repeat events sr1", 8'(ev_cnt[1]), 8'd2);
        chk("repeat events sr0", 8'(ev_cnt[0]), 8'd4);

        pool = '{8'hE0, 8'hF0, 8'hF0, 8'h12, 8'h59, 8'h58, 8'hAA, 8'hFA,
                 8'h1C, 8'h1C, 8'h32, 8'h21, 8'h75, 8'h00, 8'h2B, 8'hFE};
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 59) == 0) begin
                repeat (TMO + 2) cyc(1'b0, 8'h00, 1'($urandom_range(0, 1)));
            end else begin
                cyc(1'($urandom_range(0, 99) < 45), pool[$urandom_range(0, 15)],
                    1'($urandom_range(0, 99) < 70));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
